// File: rtl/chatmask_pkg.sv
// rtl/chatmask_pkg.sv - shared defaults, counter width helper and per-channel output bundle
package chatmask_pkg;

    localparam int unsigned DEF_CH          = 4;
    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_STABLE_CNT  = 128;
    localparam int unsigned DEF_REPEAT_DLY  = 1024;
    localparam int unsigned DEF_REPEAT_PER  = 256;

    // Bits needed to hold 0..max_val inclusive; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    typedef struct packed {
        logic level;
        logic rise;
        logic fall;
        logic rpt;
    } ch_out_t;

endpackage

// File: rtl/chatmask_multi_if.sv
// rtl/chatmask_multi_if.sv - raw button inputs and debounced/edge/repeat outputs
interface chatmask_multi_if #(
    parameter int unsigned CH = 4
);
    logic [CH-1:0] bin;
    logic [CH-1:0] repeat_en;
    logic [CH-1:0] bout;
    logic [CH-1:0] brise;
    logic [CH-1:0] bfall;
    logic [CH-1:0] brepeat;

    modport master (
        output bin,
        output repeat_en,
        input  bout,
        input  brise,
        input  bfall,
        input  brepeat
    );

    modport slave (
        input  bin,
        input  repeat_en,
        output bout,
        output brise,
        output bfall,
        output brepeat
    );
endinterface

// File: rtl/chatmask_ch.sv
// rtl/chatmask_ch.sv - one debounce channel: synchroniser, stability counter, edges, auto-repeat
module chatmask_ch
    import chatmask_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned STABLE_CNT  = DEF_STABLE_CNT,
    parameter int unsigned REPEAT_DLY  = DEF_REPEAT_DLY,
    parameter int unsigned REPEAT_PER  = DEF_REPEAT_PER
) (
    input  logic m_clock,
    input  logic p_reset_n,
    input  logic bin_i,
    input  logic repeat_en_i,
    output logic bout_o,
    output logic brise_o,
    output logic bfall_o,
    output logic brepeat_o
);

    localparam int unsigned CNT_W = cnt_width(STABLE_CNT);
    localparam int unsigned RPT_W = cnt_width(REPEAT_DLY);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(STABLE_CNT);
    localparam logic [RPT_W-1:0] RPT_LAST   = RPT_W'(REPEAT_DLY - 1);
    localparam logic [RPT_W-1:0] RPT_RELOAD =
        (REPEAT_PER >= REPEAT_DLY) ? '0 : RPT_W'(REPEAT_DLY - REPEAT_PER);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s_d_q, s_d_d;
    logic                   s_dd_q, s_dd_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [RPT_W-1:0]       rpt_q, rpt_d;
    ch_out_t                out_q, out_d;

    logic s;
    logic settle;
    logic rise;
    logic fall;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], bin_i};
        s_d_d  = s;
        s_dd_d = s_d_q;

        // Stability is judged on the delayed pair so the settled level is a
        // full STABLE_CNT+1 samples old when it is committed to bout.
        cnt_d = cnt_q;
        if (s_d_q != s_dd_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        settle = (cnt_q == CNT_MAX);
        rise   = settle && s_dd_q && !out_q.level;
        fall   = settle && !s_dd_q && out_q.level;

        out_d       = '0;
        out_d.level = settle ? s_dd_q : out_q.level;
        out_d.rise  = rise;
        out_d.fall  = fall;

        rpt_d = '0;
        if (rise) begin
            out_d.rpt = 1'b1;
        end else if (out_d.level && repeat_en_i) begin
            if (rpt_q == RPT_LAST) begin
                out_d.rpt = 1'b1;
                rpt_d     = RPT_RELOAD;
            end else begin
                rpt_d = rpt_q + RPT_W'(1);
            end
        end
    end

    always_ff @(posedge m_clock) begin
        if (!p_reset_n) begin
            sync_q <= '0;
            s_d_q  <= 1'b0;
            s_dd_q <= 1'b0;
            cnt_q  <= '0;
            rpt_q  <= '0;
            out_q  <= '0;
        end else begin
            sync_q <= sync_d;
            s_d_q  <= s_d_d;
            s_dd_q <= s_dd_d;
            cnt_q  <= cnt_d;
            rpt_q  <= rpt_d;
            out_q  <= out_d;
        end
    end

    assign bout_o    = out_q.level;
    assign brise_o   = out_q.rise;
    assign bfall_o   = out_q.fall;
    assign brepeat_o = out_q.rpt;

endmodule

// File: rtl/chatmask_multi.sv
// rtl/chatmask_multi.sv - CH independent debounce channels behind one interface
module chatmask_multi
    import chatmask_pkg::*;
#(
    parameter int unsigned CH          = DEF_CH,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned STABLE_CNT  = DEF_STABLE_CNT,
    parameter int unsigned REPEAT_DLY  = DEF_REPEAT_DLY,
    parameter int unsigned REPEAT_PER  = DEF_REPEAT_PER
) (
    input  logic             m_clock,
    input  logic             p_reset_n,
    chatmask_multi_if.slave  bus
);

    logic [CH-1:0] bout_w;
    logic [CH-1:0] brise_w;
    logic [CH-1:0] bfall_w;
    logic [CH-1:0] brepeat_w;

    for (genvar g = 0; g < CH; g++) begin : g_ch
        chatmask_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .STABLE_CNT  (STABLE_CNT),
            .REPEAT_DLY  (REPEAT_DLY),
            .REPEAT_PER  (REPEAT_PER)
        ) u_ch (
            .m_clock     (m_clock),
            .p_reset_n   (p_reset_n),
            .bin_i       (bus.bin[g]),
            .repeat_en_i (bus.repeat_en[g]),
            .bout_o      (bout_w[g]),
            .brise_o     (brise_w[g]),
            .bfall_o     (bfall_w[g]),
            .brepeat_o   (brepeat_w[g])
        );
    end

    assign bus.bout    = bout_w;
    assign bus.brise   = brise_w;
    assign bus.bfall   = bfall_w;
    assign bus.brepeat = brepeat_w;

endmodule

// File: tb/tb_chatmask_multi.sv
// tb/tb_chatmask_multi.sv - scoreboard bench for chatmask_multi
module tb_chatmask_multi;

    localparam int CH  = 2;
    localparam int SS  = 2;
    localparam int SC  = 4;
    localparam int RD  = 10;
    localparam int RP  = 3;
    localparam int LAT = SS + SC + 2;

    localparam int K_RISE = 0;
    localparam int K_FALL = 1;
    localparam int K_RPT  = 2;

    typedef struct {
        int t;
        int ch;
        int kind;
    } ev_t;

    logic m_clock = 1'b0;
    logic p_reset_n;
    int   t_now = 0;
    logic rst_edge = 1'b1;
    int   total = 0;
    int   bad = 0;
    logic [CH-1:0] exp_bout = '0;
    ev_t  sb[$];

    chatmask_multi_if #(.CH(CH)) bus();

    chatmask_multi #(
        .CH          (CH),
        .SYNC_STAGES (SS),
        .STABLE_CNT  (SC),
        .REPEAT_DLY  (RD),
        .REPEAT_PER  (RP)
    ) dut (
        .m_clock   (m_clock),
        .p_reset_n (p_reset_n),
        .bus       (bus)
    );

    always #5 m_clock = ~m_clock;

    always @(posedge m_clock) begin
        t_now    <= t_now + 1;
        rst_edge <= !p_reset_n;
    end

    task automatic push(input int t, input int ch, input int kind);
        ev_t e;
        e.t    = t;
        e.ch   = ch;
        e.kind = kind;
        sb.push_back(e);
    endtask

    task automatic press(input int t, input int ch);
        push(t, ch, K_RISE);
        push(t, ch, K_RPT);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge m_clock);
    endtask

    task automatic monitor();
        logic [CH-1:0] er, ef, ep;
        forever begin
            @(negedge m_clock);
            if (rst_edge) exp_bout = '0;
            er = '0;
            ef = '0;
            ep = '0;
            for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
                if (sb[i].t == t_now) begin
                    if (sb[i].kind == K_RISE) er[sb[i].ch] = 1'b1;
                    else if (sb[i].kind == K_FALL) ef[sb[i].ch] = 1'b1;
                    else ep[sb[i].ch] = 1'b1;
                    sb.delete(i);
                end
            end
            exp_bout = (exp_bout | er) & ~ef;
            total++;
            if (bus.bout !== exp_bout) begin
                bad++;
                $display("FAIL bout t=%0d got=%b want=%b", t_now, bus.bout, exp_bout);
            end
            total++;
            if (bus.brise !== er) begin
                bad++;
                $display("FAIL brise t=%0d got=%b want=%b", t_now, bus.brise, er);
            end
            total++;
            if (bus.bfall !== ef) begin
                bad++;
                $display("FAIL bfall t=%0d got=%b want=%b", t_now, bus.bfall, ef);
            end
            total++;
            if (bus.brepeat !== ep) begin
                bad++;
                $display("FAIL brepeat t=%0d got=%b want=%b", t_now, bus.brepeat, ep);
            end
        end
    endtask

    task automatic test_reset();
        int t0;
        p_reset_n     = 1'b0;
        bus.bin       = '0;
        bus.repeat_en = '0;
        step(3);
        total++;
        if ({bus.bout, bus.brise, bus.bfall, bus.brepeat} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=0", {bus.bout, bus.brise, bus.bfall, bus.brepeat});
        end
        p_reset_n  = 1'b1;
        bus.bin[0] = 1'b1;
        t0 = t_now + 1;
        press(t0 + LAT, 0);
        step(LAT + 4);
        total++;
        if (bus.bout !== 2'b01) begin
            bad++;
            $display("FAIL reset_first_rise got=%b want=01", bus.bout);
        end
    endtask

    task automatic test_glitch();
        int t0;
        bus.bin[0] = 1'b0;
        t0 = t_now + 1;
        push(t0 + LAT, 0, K_FALL);
        step(LAT + 4);
        bus.bin[0] = 1'b1;
        step(4);
        bus.bin[0] = 1'b0;
        step(LAT + 6);
        total++;
        if (bus.bout !== 2'b00) begin
            bad++;
            $display("FAIL glitch4_level got=%b want=00", bus.bout);
        end
        bus.bin[0] = 1'b1;
        t0 = t_now + 1;
        press(t0 + LAT, 0);
        step(5);
        bus.bin[0] = 1'b0;
        push(t0 + 5 + LAT, 0, K_FALL);
        step(LAT + 6);
    endtask

    task automatic test_repeat();
        int t0;
        int hold;
        hold = 24;
        bus.repeat_en[0] = 1'b1;
        bus.bin[0]       = 1'b1;
        t0 = t_now + 1;
        press(t0 + LAT, 0);
        for (int r = LAT + RD; r < hold + LAT; r += RP) push(t0 + r, 0, K_RPT);
        step(hold);
        bus.bin[0] = 1'b0;
        push(t0 + hold + LAT, 0, K_FALL);
        step(LAT + 6);
        bus.repeat_en[0] = 1'b0;
    endtask

    task automatic test_repeat_en();
        int t0;
        int q;
        int rel;
        bus.repeat_en[0] = 1'b0;
        bus.bin[0]       = 1'b1;
        t0 = t_now + 1;
        press(t0 + LAT, 0);
        step(14);
        bus.repeat_en[0] = 1'b1;
        q   = t_now + 1;
        rel = t0 + 30;
        for (int r = q + RD - 1; r < rel + LAT; r += RP) push(r, 0, K_RPT);
        step(16);
        bus.bin[0] = 1'b0;
        push(rel + LAT, 0, K_FALL);
        step(LAT + 6);
        bus.repeat_en[0] = 1'b0;
    endtask

    task automatic test_dual();
        int t0;
        bus.bin = 2'b11;
        t0 = t_now + 1;
        press(t0 + LAT, 0);
        press(t0 + LAT, 1);
        step(LAT + 4);
        bus.bin = 2'b00;
        t0 = t_now + 1;
        push(t0 + LAT, 0, K_FALL);
        push(t0 + LAT, 1, K_FALL);
        step(LAT + 4);
        bus.bin[0] = 1'b1;
        t0 = t_now + 1;
        press(t0 + LAT, 0);
        for (int i = 0; i < 12; i++) begin
            bus.bin[1] = ((i / 2) % 2) == 1;
            step(1);
        end
        bus.bin[1] = 1'b0;
        step(LAT + 4);
        total++;
        if (bus.bout !== 2'b01) begin
            bad++;
            $display("FAIL chatter_isolation got=%b want=01", bus.bout);
        end
        bus.bin[0] = 1'b0;
        t0 = t_now + 1;
        push(t0 + LAT, 0, K_FALL);
        step(LAT + 4);
    endtask

    task automatic test_reset_mid();
        int t0;
        bus.repeat_en[0] = 1'b1;
        bus.bin[0]       = 1'b1;
        t0 = t_now + 1;
        press(t0 + LAT, 0);
        push(t0 + LAT + RD, 0, K_RPT);
        push(t0 + LAT + RD + RP, 0, K_RPT);
        step(LAT + RD + RP + 1);
        p_reset_n = 1'b0;
        step(2);
        total++;
        if ({bus.bout, bus.brise, bus.bfall, bus.brepeat} !== '0) begin
            bad++;
            $display("FAIL midreset_outputs got=%b want=0", {bus.bout, bus.brise, bus.bfall, bus.brepeat});
        end
        p_reset_n = 1'b1;
        t0 = t_now + 1;
        press(t0 + LAT, 0);
        push(t0 + LAT + RD, 0, K_RPT);
        step(LAT + RD + 2);
        bus.bin       = '0;
        bus.repeat_en = '0;
        step(2);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
        end
    endtask

    initial begin
        p_reset_n     = 1'b0;
        bus.bin       = '0;
        bus.repeat_en = '0;
        fork
            monitor();
        join_none
        test_reset();
        test_glitch();
        test_repeat();
        test_repeat_en();
        test_dual();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
